// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter
// Description : Shares one single-port RAM between a port-A burst reader and
//               a port-B single-access requester. Optional starvation guard
//               for port B enabled by macro SPRAM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_arbiter #(
    parameter int addr_width = 10,
    parameter int data_width = 16,
    parameter int max_wait   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    // port A: burst reader
    input  logic                  a_start,
    input  logic [addr_width-1:0] a_base,
    input  logic [addr_width:0]   a_len,
    output logic                  a_busy,
    output logic [data_width-1:0] a_rdata,
    output logic                  a_rvalid,
    output logic                  a_done,
    // port B: single access
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_wdata,
    output logic                  b_ack,
    output logic [data_width-1:0] b_rdata,
    output logic                  b_rvalid,
    // single-port RAM
    output logic [addr_width-1:0] ram_address,
    output logic [data_width-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  ram_cs,
    input  logic [data_width-1:0] ram_q
);

    localparam logic [addr_width-1:0] c_PTR_ONE = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width:0]   c_CNT_ONE = {{addr_width{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [addr_width-1:0] r_ptr;
    logic [addr_width-1:0] w_ptr_nxt;
    logic [addr_width:0]   r_count;
    logic [addr_width:0]   w_count_nxt;
    logic                  r_busy;
    logic                  r_a_pend;
    logic                  r_done;
    logic                  r_b_pend;
    logic                  w_a_accept;
    logic                  w_a_issue;
    logic                  w_b_grant;
    logic                  w_wait_hit;

`ifdef SPRAM_ARB_STARVE_GUARD_EN
    localparam int c_WAIT_W = $clog2(max_wait + 2);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(max_wait);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    logic [c_WAIT_W-1:0] r_wait;

    assign w_wait_hit = (r_wait >= c_WAIT_MAX);

    // Saturates at max_wait; once there, B owns the next burst cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_b_grant) begin
            r_wait <= '0;
        end else if ((r_state == ST_BURST) && b_req && !w_wait_hit) begin
            r_wait <= r_wait + c_WAIT_ONE;
        end
    end
`else
    assign w_wait_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_a_accept  = 1'b0;
        w_a_issue   = 1'b0;
        w_b_grant   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_b_grant = b_req;
                if (a_start && !r_busy) begin
                    w_a_accept  = 1'b1;
                    w_ptr_nxt   = a_base;
                    w_count_nxt = a_len;
                    if (a_len != '0) begin
                        w_state_nxt = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (b_req && w_wait_hit) begin
                    w_b_grant = 1'b1;
                end else begin
                    w_a_issue   = 1'b1;
                    w_ptr_nxt   = r_ptr + c_PTR_ONE;
                    w_count_nxt = r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Reset must silence the RAM and port B within the same cycle.
        if (reset) begin
            w_a_accept = 1'b0;
            w_a_issue  = 1'b0;
            w_b_grant  = 1'b0;
        end
    end

    always_comb begin
        ram_cs      = w_b_grant | w_a_issue;
        ram_wren    = w_b_grant & b_we;
        ram_address = w_b_grant ? b_addr : (w_a_issue ? r_ptr : '0);
        ram_data    = w_b_grant ? b_wdata : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_a_pend <= 1'b0;
            r_done   <= 1'b0;
            r_b_pend <= 1'b0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_count  <= w_count_nxt;
            r_a_pend <= w_a_issue;
            r_b_pend <= w_b_grant & ~b_we;
            // Done tracks the final read return, or the empty burst directly.
            r_done   <= (w_a_issue && (r_count == c_CNT_ONE)) ||
                        (w_a_accept && (a_len == '0));
            if (w_a_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Status is masked during reset so an aborted burst emits nothing more.
    assign a_busy   = r_busy & ~reset;
    assign a_rvalid = r_a_pend & ~reset;
    assign a_done   = r_done & ~reset;
    assign a_rdata  = a_rvalid ? ram_q : '0;
    assign b_ack    = w_b_grant;
    assign b_rvalid = r_b_pend & ~reset;
    assign b_rdata  = b_rvalid ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_spram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_arbiter
// Description : Randomized scoreboard bench for spram_arbiter with a RAM model
//               and a reference memory image of expected contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          a_start;
    logic [AW-1:0] a_base;
    logic [AW:0]   a_len;
    logic          a_busy;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;
    logic          a_done;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic          ram_cs;
    logic [DW-1:0] ram_q;

    spram_arbiter #(.addr_width(AW), .data_width(DW), .max_wait(4)) dut (
        .clock(clock), .reset(reset),
        .a_start(a_start), .a_base(a_base), .a_len(a_len), .a_busy(a_busy),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_cs(ram_cs), .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM with registered read data.
    logic [DW-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
        ram_q <= '0;
    end
    always @(posedge clock) begin
        if (ram_cs) begin
            if (ram_wren) mem[ram_address] <= ram_data;
            else          ram_q <= mem[ram_address];
        end
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } a_exp_t;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    a_exp_t        a_q[$];
    logic [DW-1:0] b_q[$];
    int            n_checks;
    int            n_fail;
    int            zero_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents read data.
    always @(negedge clock) begin
        if (a_rvalid) begin
            if (a_q.size() == 0) begin
                check("a_rvalid_unexpected", 32'(a_rvalid), 32'h0);
            end else begin
                a_exp_t e;
                e = a_q.pop_front();
                check("a_rdata", 32'(a_rdata), 32'(e.d));
                check("a_done_with_last", 32'(a_done), 32'(e.last));
            end
        end else if (a_done) begin
            if (zero_done > 0) zero_done--;
            else check("a_done_unexpected", 32'(a_done), 32'h0);
        end
        if (b_rvalid) begin
            if (b_q.size() == 0) check("b_rvalid_unexpected", 32'(b_rvalid), 32'h0);
            else check("b_rdata", 32'(b_rdata), 32'(b_q.pop_front()));
        end
        if (b_ack && !b_req) check("b_ack_without_req", 32'(b_ack), 32'h0);
    end

    task automatic b_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int exp_wait);
        int w;
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
        #1;
        w = 0;
        while (!b_ack && w < 200) begin
            step();
            w++;
        end
        check("b_ack_latency", 32'(w), 32'(exp_wait));
        if (we) ref_mem[addr] = data;
        else    b_q.push_back(ref_mem[addr]);
        step();
        b_req = 1'b0;
        check("b_rvalid_after_ack", 32'(b_rvalid), 32'(!we));
    endtask

    task automatic a_burst(input logic [AW-1:0] base, input int len, input bit restart);
        int busy_c, rv_c, cs_c, first_rv, done_c;
        logic [AW-1:0] addr;
        a_start = 1'b1; a_base = base; a_len = (AW+1)'(len);
        for (int i = 0; i < len; i++) begin
            addr = base + AW'(i);
            a_q.push_back('{d: ref_mem[addr], last: (i == len - 1)});
        end
        if (len == 0) zero_done++;
        step();
        a_start = 1'b0;
        busy_c = 0; rv_c = 0; cs_c = 0; first_rv = -1; done_c = -1;
        for (int c = 1; c < len + 20; c++) begin
            if (!a_busy) break;
            busy_c++;
            if (ram_cs) cs_c++;
            if (a_rvalid) begin
                rv_c++;
                if (first_rv < 0) first_rv = c;
            end
            if (a_done) done_c = c;
            if (restart && c == 2) begin
                a_start = 1'b1; a_base = ~base; a_len = (AW+1)'(3);
            end else begin
                a_start = 1'b0;
            end
            step();
        end
        a_start = 1'b0;
        check("a_busy_cycles", 32'(busy_c), 32'(len + 1));
        check("a_ram_cs_cycles", 32'(cs_c), 32'(len));
        check("a_rvalid_count", 32'(rv_c), 32'(len));
        check("a_done_cycle", 32'(done_c), 32'(len + 1));
        if (len > 0) check("a_first_rvalid", 32'(first_rv), 32'd2);
    endtask

    // 16-word burst with a port-B read raised on the first burst cycle.
    task automatic overlap();
        int ack_c, rv_c, cs_c, done_c;
        logic [AW-1:0] base, x, addr;
        base = AW'($urandom);
        x    = AW'($urandom);
        for (int i = 0; i < 16; i++) begin
            addr = base + AW'(i);
            a_q.push_back('{d: ref_mem[addr], last: (i == 15)});
        end
        a_start = 1'b1; a_base = base; a_len = (AW+1)'(16);
        step();
        a_start = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = x;
        #1;
        ack_c = -1; rv_c = 0; cs_c = 0; done_c = -1;
        for (int c = 1; c <= 24; c++) begin
            if (b_ack && b_req) begin
                ack_c = c;
                b_q.push_back(ref_mem[x]);
            end
            if (ram_cs) cs_c++;
            if (a_rvalid) rv_c++;
            if (a_done) done_c = c;
            step();
            if (ack_c > 0) b_req = 1'b0;
            #1;
        end
        b_req = 1'b0;
`ifdef SPRAM_ARB_STARVE_GUARD_EN
        check("ovl_b_ack_cycle", 32'(ack_c), 32'd5);
        check("ovl_done_cycle", 32'(done_c), 32'd18);
`else
        check("ovl_b_ack_cycle", 32'(ack_c), 32'd17);
        check("ovl_done_cycle", 32'(done_c), 32'd17);
`endif
        check("ovl_ram_cs_cycles", 32'(cs_c), 32'd17);
        check("ovl_rvalid_count", 32'(rv_c), 32'd16);
    endtask

    task automatic reset_mid();
        int rv_c, cs_c, done_c;
        logic [AW-1:0] base, addr;
        base = AW'($urandom);
        for (int i = 0; i < 8; i++) begin
            addr = base + AW'(i);
            a_q.push_back('{d: ref_mem[addr], last: (i == 7)});
        end
        a_start = 1'b1; a_base = base; a_len = (AW+1)'(8);
        step();
        a_start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_mid_ram_cs", 32'(ram_cs), 32'h0);
        check("rst_mid_a_rvalid", 32'(a_rvalid), 32'h0);
        check("rst_mid_a_done", 32'(a_done), 32'h0);
        a_q.delete();
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_a_busy", 32'(a_busy), 32'h0);
        rv_c = 0; cs_c = 0; done_c = 0;
        for (int c = 0; c < 12; c++) begin
            if (a_rvalid) rv_c++;
            if (ram_cs) cs_c++;
            if (a_done) done_c++;
            step();
        end
        check("rst_mid_no_rvalid", 32'(rv_c), 32'h0);
        check("rst_mid_no_cs", 32'(cs_c), 32'h0);
        check("rst_mid_no_done", 32'(done_c), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; zero_done = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
        reset = 1'b1; a_start = 1'b0; a_base = '0; a_len = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = AW'(5); b_wdata = 16'hDEAD;
        step();
        check("rst_ram_cs", 32'(ram_cs), 32'h0);
        check("rst_ram_wren", 32'(ram_wren), 32'h0);
        check("rst_b_ack", 32'(b_ack), 32'h0);
        b_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("rst_a_busy", 32'(a_busy), 32'h0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        check("rst_a_done", 32'(a_done), 32'h0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        check("rst_a_rdata", 32'(a_rdata), 32'h0);
        check("rst_b_rdata", 32'(b_rdata), 32'h0);

        b_access(1'b1, AW'(5), 16'h1234, 0);
        b_access(1'b0, AW'(5), '0, 0);
        a_burst(AW'(10'h3FE), 4, 1'b0);
        a_burst(AW'(10'h020), 0, 1'b0);
        a_burst(AW'(10'h100), 5, 1'b1);
        overlap();
        step();
        reset_mid();
        a_burst(AW'(10'h055), 8, 1'b0);
        a_burst(AW'(10'h100), DEPTH, 1'b0);

        repeat (80) begin
            repeat ($urandom_range(0, 2)) step();
            case ($urandom_range(0, 3))
                0:       b_access(1'b1, AW'($urandom), DW'($urandom), 0);
                1:       b_access(1'b0, AW'($urandom), '0, 0);
                default: a_burst(AW'($urandom), int'($urandom_range(0, 24)), 1'($urandom));
            endcase
        end
        repeat (4) step();
        check("a_queue_drained", 32'(a_q.size()), 32'h0);
        check("b_queue_drained", 32'(b_q.size()), 32'h0);
        check("zero_done_drained", 32'(zero_done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter addr_width, default 10: RAM address width; addresses wrap modulo 2**addr_width.
REQ-002 Parameter data_width, default 16: RAM word width.
REQ-003 Parameter max_wait, default 4: number of burst cycles port B may wait before it is granted a slot (guard build only).
REQ-004 clock  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 a_start  in  1  one-cycle pulse requesting a port-A burst read.
REQ-007 a_base  in  addr_width  burst start address, sampled with a_start.
REQ-008 a_len  in  addr_width+1  burst length in words (0 to 2**addr_width), sampled with a_start.
REQ-009 a_busy  out  1  high from the cycle after accepted a_start until the cycle after a_done.
REQ-010 a_rdata  out  data_width  burst read word.
REQ-011 a_rvalid  out  1  a_rdata valid this cycle.
REQ-012 a_done  out  1  one-cycle pulse marking burst completion.
REQ-013 b_req  in  1  port-B single-access request, held until b_ack.
REQ-014 b_we  in  1  port-B write (1) or read (0).
REQ-015 b_addr  in  addr_width  port-B address.
REQ-016 b_wdata  in  data_width  port-B write data.
REQ-017 b_ack  out  1  combinational; high in the cycle port B's access is issued.
REQ-018 b_rdata  out  data_width  port-B read word.
REQ-019 b_rvalid  out  1  b_rdata valid this cycle.
REQ-020 ram_address  out  addr_width  to single-port RAM.
REQ-021 ram_data  out  data_width  RAM write data.
REQ-022 ram_wren  out  1  RAM write enable.
REQ-023 ram_cs  out  1  RAM chip select; high only in cycles that issue an access.
REQ-024 ram_q  in  data_width  RAM registered read data; valid one cycle after a read issue.

Function
REQ-025 FSM states IDLE and BURST; at most one RAM access per cycle.
REQ-026 IDLE: b_req granted in the same cycle (b_ack=1, ram_cs=1, ram_wren=b_we, ram_address=b_addr, ram_data=b_wdata).
REQ-027 IDLE with a_start=1: base/length latched, a_busy rises next cycle, FSM enters BURST if a_len>0; a simultaneous b_req is still served in that cycle.
REQ-028 a_len=0: no RAM access, a_done pulses the cycle after a_start, FSM stays IDLE.
REQ-029 BURST: each cycle not given to B issues a read at the pointer, then increments the pointer modulo 2**addr_width and decrements the remaining count.
REQ-030 The last issue returns FSM to IDLE next cycle; B may be granted in that next cycle.
REQ-031 Read latency: a_rvalid/a_rdata=ram_q exactly one cycle after each A issue, in address order; a_done pulses together with the final a_rvalid.
REQ-032 Port-B read: b_rvalid/b_rdata=ram_q one cycle after b_ack; writes produce no b_rvalid.
REQ-033 a_start while a_busy=1 is ignored.
REQ-034 b_req while b_ack=0 stalls with no side effects; b_ack never asserts without b_req.

Reset
REQ-035 While reset=1: ram_cs=0, ram_wren=0, b_ack=0; at the next edge FSM=IDLE and the pointer, count and wait counter are zeroed.
REQ-036 After reset: a_busy, a_rvalid, a_done and b_rvalid are 0; a_rdata and b_rdata are 0.
REQ-037 Reset mid-burst aborts the burst: no a_done and no further a_rvalid are produced.

Configuration
REQ-038 Macro SPRAM_ARB_STARVE_GUARD_EN defined: a wait counter increments on each BURST cycle with b_req=1 and b_ack=0.
REQ-039 With the macro defined, the counter reaching max_wait grants B the next BURST cycle instead of an A issue; the counter clears on b_ack.
REQ-040 Macro undefined: B is never granted in BURST and the wait counter is absent.

Verification
REQ-041 Idle B write then read: write 0x1234 to 0x005, then read 0x005 -> b_ack in the request cycle; b_rvalid one cycle later with b_rdata=0x1234.
REQ-042 Burst a_base=0x3FE, a_len=4 over a RAM preloaded with word=address -> four a_rvalid words 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; a_done with the fourth.
REQ-043 Guard build, max_wait=4, b_req raised on the first burst cycle of a 16-word burst -> b_ack on the 5th burst cycle, one bubble in the a_rvalid stream, 16 words delivered in order.
REQ-044 Guard undefined, same stimulus -> b_ack only in the cycle after the 16th A issue.
REQ-045 a_len=0 -> no ram_cs; a_done the cycle after a_start; a_start repeated during a_busy -> ignored, no extra words.
REQ-046 Reset asserted on the 3rd cycle of an 8-word burst -> ram_cs=0 immediately; no a_done; next a_start is accepted normally.
